// File: rtl/fft_butterfly_sequencer_pkg.sv
// Shared types and defaults for the radix-2 DIT butterfly sequencer.
package fft_pkg;
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    localparam int DEF_LOG2N    = 4;
    localparam int DEF_RD_LAT   = 1;
    localparam int DEF_BFLY_LAT = 2;

    // Cycles between a read issue and the matching write-back.
    function automatic int calc_lat(input int rd_lat, input int bfly_lat);
        return rd_lat + bfly_lat;
    endfunction
endpackage

// File: rtl/fft_butterfly_sequencer_if.sv
// Controller/memory-side bundle of the butterfly sequencer.
// FFT_INVERSE_EN adds i_inverse / o_tw_conj for IFFT runs.
interface fft_butterfly_sequencer_if
    import fft_pkg::*;
#(
    parameter int LOG2N = DEF_LOG2N
);
    logic             i_start;
    logic             o_busy;
    logic             o_done;
    logic             o_rd_en;
    logic [LOG2N-1:0] o_rd_addr_a;
    logic [LOG2N-1:0] o_rd_addr_b;
    logic [LOG2N-2:0] o_tw_addr;
    logic             o_wr_en;
    logic [LOG2N-1:0] o_wr_addr_a;
    logic [LOG2N-1:0] o_wr_addr_b;
    logic [LOG2N-1:0] o_stage;
`ifdef FFT_INVERSE_EN
    logic             i_inverse;
    logic             o_tw_conj;
`endif

    modport master (
        output i_start,
`ifdef FFT_INVERSE_EN
        output i_inverse,
        input  o_tw_conj,
`endif
        input  o_busy, o_done, o_rd_en, o_rd_addr_a, o_rd_addr_b, o_tw_addr,
        input  o_wr_en, o_wr_addr_a, o_wr_addr_b, o_stage
    );

    modport slave (
        input  i_start,
`ifdef FFT_INVERSE_EN
        input  i_inverse,
        output o_tw_conj,
`endif
        output o_busy, o_done, o_rd_en, o_rd_addr_a, o_rd_addr_b, o_tw_addr,
        output o_wr_en, o_wr_addr_a, o_wr_addr_b, o_stage
    );
endinterface

// File: rtl/fft_butterfly_sequencer_addr_delay.sv
// Depth-DEPTH shift register carrying {valid, addr_a, addr_b} from read issue to write-back.
module fft_addr_delay #(
    parameter int DEPTH = 3,
    parameter int W     = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_vld,
    input  logic [W-1:0] in_a,
    input  logic [W-1:0] in_b,
    output logic         out_vld,
    output logic [W-1:0] out_a,
    output logic [W-1:0] out_b
);
    logic [DEPTH-1:0][2*W:0] pipe;

    always_ff @(posedge clk) begin
        if (rst) begin
            pipe <= '0;
        end else begin
            pipe[0] <= {in_vld, in_a, in_b};
            for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
        end
    end

    assign {out_vld, out_a, out_b} = pipe[DEPTH-1];
endmodule

// File: rtl/fft_butterfly_sequencer.sv
// Issues per-stage butterfly read/twiddle addresses and delayed write-backs for an in-place FFT.
// FFT_INVERSE_EN: latch i_inverse on start and drive o_tw_conj for the run.
module fft_butterfly_sequencer
    import fft_pkg::*;
#(
    parameter int LOG2N    = DEF_LOG2N,
    parameter int RD_LAT   = DEF_RD_LAT,
    parameter int BFLY_LAT = DEF_BFLY_LAT
) (
    input logic                     clk,
    input logic                     rst,
    fft_butterfly_sequencer_if.slave bus
);
    localparam int L      = calc_lat(RD_LAT, BFLY_LAT);
    localparam int HALF_N = 1 << (LOG2N - 1);
    localparam int KW     = LOG2N - 1;
    localparam int CW     = $clog2(L + 1);

    state_t           state, state_n;
    logic [LOG2N-1:0] s_q, s_n;
    logic [KW-1:0]    k_q, k_n;
    logic [CW-1:0]    cnt_q, cnt_n;
    logic             rd_en_q, rd_en_n, busy_q, busy_n, done_q, done_n;
    logic [LOG2N-1:0] rd_a_q, rd_a_n, rd_b_q, rd_b_n;
    logic [LOG2N-2:0] tw_q, tw_n;
    logic             conj_q, conj_n;
    logic             iss;
    int               iss_s, iss_k;

    // a = grp*2*half + pos, with grp = k>>s and pos = k mod 2^s
    function automatic logic [LOG2N-1:0] addr_a(input int s, input int k);
        return LOG2N'(((k >> s) << (s + 1)) | (k & ((1 << s) - 1)));
    endfunction

    function automatic logic [LOG2N-2:0] tw_idx(input int s, input int k);
        return (LOG2N-1)'((k & ((1 << s) - 1)) << (LOG2N - 1 - s));
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            s_q     <= '0;
            k_q     <= '0;
            cnt_q   <= '0;
            rd_en_q <= 1'b0;
            rd_a_q  <= '0;
            rd_b_q  <= '0;
            tw_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            conj_q  <= 1'b0;
        end else begin
            state   <= state_n;
            s_q     <= s_n;
            k_q     <= k_n;
            cnt_q   <= cnt_n;
            rd_en_q <= rd_en_n;
            rd_a_q  <= rd_a_n;
            rd_b_q  <= rd_b_n;
            tw_q    <= tw_n;
            busy_q  <= busy_n;
            done_q  <= done_n;
            conj_q  <= conj_n;
        end
    end

    always_comb begin
        state_n = state;
        s_n     = s_q;
        k_n     = k_q;
        cnt_n   = cnt_q;
        rd_en_n = 1'b0;
        rd_a_n  = rd_a_q;
        rd_b_n  = rd_b_q;
        tw_n    = tw_q;
        busy_n  = busy_q;
        done_n  = 1'b0;
        conj_n  = conj_q;
        iss     = 1'b0;
        iss_s   = int'(s_q);
        iss_k   = int'(k_q);
        case (state)
            IDLE: begin
                conj_n = 1'b0;
                if (bus.i_start) begin
                    state_n = ISSUE;
                    s_n     = '0;
                    k_n     = '0;
                    busy_n  = 1'b1;
                    iss     = 1'b1;
                    iss_s   = 0;
                    iss_k   = 0;
`ifdef FFT_INVERSE_EN
                    conj_n  = bus.i_inverse;
`endif
                end
            end
            ISSUE: begin
                if (k_q == KW'(HALF_N - 1)) begin
                    state_n = DRAIN;
                    cnt_n   = '0;
                end else begin
                    k_n   = k_q + KW'(1);
                    iss   = 1'b1;
                    iss_k = int'(k_q) + 1;
                end
            end
            DRAIN: begin
                // Next stage starts only once the last write of this stage has left the delay line.
                if (cnt_q == CW'(L - 1)) begin
                    if (s_q == LOG2N'(LOG2N - 1)) begin
                        state_n = DONE;
                        busy_n  = 1'b0;
                        done_n  = 1'b1;
                    end else begin
                        state_n = ISSUE;
                        s_n     = s_q + LOG2N'(1);
                        k_n     = '0;
                        iss     = 1'b1;
                        iss_s   = int'(s_q) + 1;
                        iss_k   = 0;
                    end
                end else begin
                    cnt_n = cnt_q + CW'(1);
                end
            end
            DONE: begin
                state_n = IDLE;
                conj_n  = 1'b0;
            end
            default: state_n = IDLE;
        endcase
        if (iss) begin
            rd_en_n = 1'b1;
            rd_a_n  = addr_a(iss_s, iss_k);
            rd_b_n  = addr_a(iss_s, iss_k) + LOG2N'(1 << iss_s);
            tw_n    = tw_idx(iss_s, iss_k);
        end
    end

    logic             wr_en;
    logic [LOG2N-1:0] wr_a, wr_b;

    fft_addr_delay #(.DEPTH(L), .W(LOG2N)) u_dly (
        .clk     (clk),
        .rst     (rst),
        .in_vld  (rd_en_q),
        .in_a    (rd_a_q),
        .in_b    (rd_b_q),
        .out_vld (wr_en),
        .out_a   (wr_a),
        .out_b   (wr_b)
    );

    assign bus.o_busy      = busy_q;
    assign bus.o_done      = done_q;
    assign bus.o_rd_en     = rd_en_q;
    assign bus.o_rd_addr_a = rd_a_q;
    assign bus.o_rd_addr_b = rd_b_q;
    assign bus.o_tw_addr   = tw_q;
    assign bus.o_wr_en     = wr_en;
    assign bus.o_wr_addr_a = wr_a;
    assign bus.o_wr_addr_b = wr_b;
    assign bus.o_stage     = s_q;
`ifdef FFT_INVERSE_EN
    assign bus.o_tw_conj   = conj_q;
`else
    logic unused_conj;
    assign unused_conj = conj_q;
`endif
endmodule

// File: tb/tb_fft_butterfly_sequencer.sv
// Randomized bench for fft_butterfly_sequencer against a cycle-index model of the FFT schedule.
module tb_fft_butterfly_sequencer;
    import fft_pkg::*;

    localparam int LOG2N = 4;
    localparam int L     = 3;
    localparam int N     = 1 << LOG2N;
    localparam int HN    = N / 2;
    localparam int P     = HN + L;
    localparam int TOT   = LOG2N * P;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fft_butterfly_sequencer_if #(.LOG2N(LOG2N)) bus ();

    fft_butterfly_sequencer #(.LOG2N(LOG2N), .RD_LAT(1), .BFLY_LAT(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int fails  = 0;
    int t      = 0;     // cycle index since accepted start (0 = idle)
    bit armed     = 1'b0;
    bit after_rst = 1'b0;
    int wrcnt     = 0;
    bit inv_lat   = 1'b0;
    bit inv_drv   = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at t=%0d: got %0d expected %0d", name, t, act, exp);
        end
    endtask

    // Butterfly k of stage s: spec address rule in plain arithmetic.
    function automatic int m_a(input int s, input int k);
        int half = 2 ** s;
        return (k / half) * 2 * half + (k % half);
    endfunction
    function automatic int m_tw(input int s, input int k);
        int half = 2 ** s;
        return (k % half) * (2 ** (LOG2N - 1 - s));
    endfunction

    // Reference: advances on each edge from the spec's schedule.
    always @(posedge clk) begin
        if (rst) begin
            t = 0; after_rst = 1'b1; armed = 1'b1;
        end else if (t == 0) begin
            if (bus.i_start) begin
                t = 1; after_rst = 1'b0; wrcnt = 0; inv_lat = inv_drv;
            end
        end else if (t == TOT + 1) begin
            t = 0;
        end else begin
            t = t + 1;
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            int eb, ed, erd, ewr, j, s, u, ju, su;
            eb  = (t >= 1 && t <= TOT) ? 1 : 0;
            ed  = (t == TOT + 1) ? 1 : 0;
            j   = (t - 1) % P;
            s   = (t - 1) / P;
            erd = (eb == 1 && j < HN) ? 1 : 0;
            u   = t - L;
            ju  = (u - 1) % P;
            su  = (u - 1) / P;
            ewr = (t > 0 && u >= 1 && u <= TOT && ju < HN) ? 1 : 0;
            if (bus.o_wr_en === 1'b1 && t > 0) wrcnt++;
            chk("busy", int'(bus.o_busy), eb);
            chk("done", int'(bus.o_done), ed);
            chk("rd_en", int'(bus.o_rd_en), erd);
            chk("wr_en", int'(bus.o_wr_en), ewr);
            if (erd == 1) begin
                chk("rd_a", int'(bus.o_rd_addr_a), m_a(s, j));
                chk("rd_b", int'(bus.o_rd_addr_b), m_a(s, j) + 2 ** s);
                chk("tw", int'(bus.o_tw_addr), m_tw(s, j));
            end
            if (ewr == 1) begin
                chk("wr_a", int'(bus.o_wr_addr_a), m_a(su, ju));
                chk("wr_b", int'(bus.o_wr_addr_b), m_a(su, ju) + 2 ** su);
            end
            if (eb == 1) chk("stage", int'(bus.o_stage), s);
`ifdef FFT_INVERSE_EN
            chk("tw_conj", int'(bus.o_tw_conj), (t >= 1 && t <= TOT + 1) ? int'(inv_lat) : 0);
`endif
            if (t == 0 && after_rst) begin
                chk("rst_rd_a", int'(bus.o_rd_addr_a), 0);
                chk("rst_rd_b", int'(bus.o_rd_addr_b), 0);
                chk("rst_tw", int'(bus.o_tw_addr), 0);
                chk("rst_wr_a", int'(bus.o_wr_addr_a), 0);
                chk("rst_wr_b", int'(bus.o_wr_addr_b), 0);
                chk("rst_stage", int'(bus.o_stage), 0);
            end
            // Hand-derived points for N=16, L=3.
            case (t)
                1:  begin chk("c1_rd_a", int'(bus.o_rd_addr_a), 0); chk("c1_rd_b", int'(bus.o_rd_addr_b), 1); end
                4:  begin chk("c4_wr_en", int'(bus.o_wr_en), 1); chk("c4_wr_a", int'(bus.o_wr_addr_a), 0);
                          chk("c4_wr_b", int'(bus.o_wr_addr_b), 1); end
                8:  begin chk("c8_rd_a", int'(bus.o_rd_addr_a), 14); chk("c8_rd_b", int'(bus.o_rd_addr_b), 15); end
                11: begin chk("c11_wr_en", int'(bus.o_wr_en), 1); chk("c11_rd_en", int'(bus.o_rd_en), 0); end
                12: begin chk("c12_rd_en", int'(bus.o_rd_en), 1); chk("c12_wr_en", int'(bus.o_wr_en), 0);
                          chk("c12_rd_b", int'(bus.o_rd_addr_b), 2); end
                13: begin chk("c13_rd_a", int'(bus.o_rd_addr_a), 1); chk("c13_rd_b", int'(bus.o_rd_addr_b), 3);
                          chk("c13_tw", int'(bus.o_tw_addr), 4); end
                39: begin chk("c39_rd_a", int'(bus.o_rd_addr_a), 5); chk("c39_rd_b", int'(bus.o_rd_addr_b), 13);
                          chk("c39_tw", int'(bus.o_tw_addr), 5); end
                44: chk("c44_busy", int'(bus.o_busy), 1);
                45: begin chk("c45_done", int'(bus.o_done), 1); chk("c45_busy", int'(bus.o_busy), 0);
                          chk("wr_count", wrcnt, 32); end
                default: ;
            endcase
        end
    end

    task automatic run(input bit noise, input int abort_at);
        int i;
        bus.i_start = 1'b1;
        inv_drv = 1'($urandom_range(0, 1));
`ifdef FFT_INVERSE_EN
        bus.i_inverse = inv_drv;
`endif
        @(negedge clk);
        for (i = 0; i < 200 && t != 0; i++) begin
            if (abort_at > 0 && t == abort_at) begin
                bus.i_start = 1'b0;
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                break;
            end
            if (t == TOT + 1) bus.i_start = 1'b1;
            else bus.i_start = noise && ($urandom_range(0, 3) == 0);
`ifdef FFT_INVERSE_EN
            bus.i_inverse = 1'($urandom_range(0, 1));
`endif
            @(negedge clk);
        end
        bus.i_start = 1'b0;
        chk("run_ends", (t == 0) ? 1 : 0, 1);
    endtask

    initial begin
        bus.i_start = 1'b0;
`ifdef FFT_INVERSE_EN
        bus.i_inverse = 1'b0;
`endif
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        run(1'b0, 0);
        repeat ($urandom_range(1, 4)) @(negedge clk);
        run(1'b1, 20);
        repeat (6) @(negedge clk);
        run(1'b1, 0);
        repeat ($urandom_range(0, 3)) @(negedge clk);
        run(1'b1, 0);
        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/fft_butterfly_sequencer.md
Name: fft_butterfly_sequencer

Overview:
- Control engine that drives the radix-2 DIT butterfly datapath through a complete in-place N-point FFT.
- Per stage, issues read address pairs (a, b) and the twiddle index to the data RAM and twiddle ROM.
- Delays each address pair by the read-plus-butterfly latency, then issues write-back of the butterfly outputs to the same addresses.
- Sits between the top-level FFT controller (start/done) and the data RAM, twiddle ROM and butterfly_unit.

Parameters:
- LOG2N, 4, log2 of FFT length N (N=16 default); legal range 2..10.
- RD_LAT, 1, data RAM and twiddle ROM read latency in cycles.
- BFLY_LAT, 2, butterfly input-to-output latency in cycles (multiplier stage plus adder stage).

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- i_start  input  1  start pulse; sampled only in IDLE
- o_busy  output  1  high from the first issue cycle through the last write cycle
- o_done  output  1  one-cycle pulse after the final write-back
- o_rd_en  output  1  read strobe to data RAM and twiddle ROM
- o_rd_addr_a  output  LOG2N  butterfly upper-input address
- o_rd_addr_b  output  LOG2N  butterfly lower-input address
- o_tw_addr  output  LOG2N-1  twiddle ROM index
- o_wr_en  output  1  write strobe for both butterfly outputs
- o_wr_addr_a  output  LOG2N  write address for output a
- o_wr_addr_b  output  LOG2N  write address for output b
- o_stage  output  LOG2N bits wide (holds values 0..LOG2N-1)  current stage index, for scaling control

Behaviour:
- Interface fixed: single clock clk; rst is synchronous and active-high.
- All outputs are registered. Reset drives every output to 0, state to IDLE, and clears the delay line.
- L = RD_LAT + BFLY_LAT (3 by default).
- States:
  - IDLE: i_start=1 goes to ISSUE; stage s=0, k=0.
  - ISSUE: o_rd_en=1 for k = 0..N/2-1, one butterfly per cycle. After k=N/2-1, go to DRAIN.
  - DRAIN: wait L cycles. Then, if s<LOG2N-1: s++, k=0, go to ISSUE. Otherwise go to DONE.
  - DONE: o_done=1 for one cycle, then IDLE.
- Address generation (stage s, butterfly k):
  - half = 2^s; pos = k mod half; grp = k >> s.
  - a = grp*2*half + pos; b = a + half.
  - tw = pos << (LOG2N-1-s).
- Write-back: o_wr_en and o_wr_addr_a/b equal o_rd_en and o_rd_addr_a/b delayed exactly L cycles, via a shift register of depth L.
- Hazard rule: the first read of stage s+1 occurs the cycle after the last write of stage s. No overlap between stages.
- Timing (i_start sampled in cycle 0):
  - First issue in cycle 1; each stage occupies N/2+L cycles.
  - o_busy high in cycles 1 .. LOG2N*(N/2+L).
  - o_done high in cycle LOG2N*(N/2+L)+1, with o_busy low in that cycle.
- Boundary conditions:
  - i_start while not IDLE is ignored.
  - i_start asserted in the same cycle as o_done is ignored.
  - rst mid-run aborts immediately: delay line is flushed, no further writes, no o_done.
  - o_rd_en=0 in DRAIN/IDLE; address outputs hold their last values (don't-care).

Optional Feature:
- Macro FFT_INVERSE_EN.
- Defined:
  - Adds input i_inverse (1 bit), latched on accepted i_start.
  - Adds output o_tw_conj (1 bit) = latched value, held for the whole run and cleared in IDLE/reset.
  - Twiddle ROM conjugates when o_tw_conj=1, giving an IFFT.
- Undefined: neither port exists; forward FFT only. Timing is identical either way.

Decomposition:
- Package fft_pkg holds: the state enum (IDLE, ISSUE, DRAIN, DONE), default LOG2N/RD_LAT/BFLY_LAT constants, and the function computing L.
- One natural sub-module: fft_addr_delay, a parameterised depth-L shift register carrying {valid, addr_a, addr_b}.

Test Plan:
- Reset then i_start=1 (LOG2N=4, L=3) -> stage 0 issues (a,b,tw) = (0,1,0), (2,3,0), …, (14,15,0) in cycles 1-8; first o_wr_en in cycle 4 with addresses 0/1.
- Stage 1 -> issues (0,2,0), (1,3,4), (4,6,0), (5,7,4), …; stage 3 -> (k, k+8, k) for k=0..7.
- Full run -> o_busy high in cycles 1-44, o_done single pulse in cycle 45; exactly 32 o_wr_en pulses in total; each wr pair equals the rd pair 3 cycles earlier.
- Stage boundary -> last write of stage 0 in cycle 11, first read of stage 1 in cycle 12; no cycle with o_rd_en and o_wr_en both high across a stage boundary.
- rst asserted in cycle 20 -> all outputs 0 in cycle 21, no o_wr_en or o_done afterwards; a new i_start restarts at stage 0.
- FFT_INVERSE_EN defined, i_inverse=1 at start -> o_tw_conj=1 during cycles 1-44 and 0 after DONE; i_start pulses mid-run are ignored.
